// File: rtl/spi_pkg.sv
// Shared types and command-byte field positions for the SPI slave mux.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_WAIT_SS
  } spi_state_t;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned ADDR_MSB   = 6;
  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned ADDR_W     = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned CNT_W      = 6;

endpackage

// File: rtl/spi_slave_mux_edge_sync.sv
// Two-flop synchronisers for the SPI pins plus one delay stage for edge detection.
module spi_edge_sync #(
  parameter int unsigned CPOL = 0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_sclk,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_sample_edge,
  output logic o_shift_edge,
  output logic o_ss_start,
  output logic o_ss_end,
  output logic o_mosi
);

  localparam logic SCLK_IDLE = (CPOL != 0);

  // [0] first sync stage, [1] synchronised value, [2] previous synchronised value
  logic [2:0] r_sclk;
  logic [2:0] r_ss;
  logic [1:0] r_mosi;
  logic       w_rise;
  logic       w_fall;

  // Reset to pin idle levels so no spurious edge appears after reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_sclk <= {3{SCLK_IDLE}};
      r_ss   <= '1;
      r_mosi <= '0;
    end else begin
      r_sclk <= {r_sclk[1:0], i_sclk};
      r_ss   <= {r_ss[1:0], i_ss_n};
      r_mosi <= {r_mosi[0], i_mosi};
    end
  end

  assign w_rise        = r_sclk[1] & ~r_sclk[2];
  assign w_fall        = ~r_sclk[1] & r_sclk[2];
  assign o_sample_edge = SCLK_IDLE ? w_fall : w_rise;
  assign o_shift_edge  = SCLK_IDLE ? w_rise : w_fall;
  assign o_ss_start    = ~r_ss[1] & r_ss[2];
  assign o_ss_end      = r_ss[1] & ~r_ss[2];
  assign o_mosi        = r_mosi[1];

endmodule

// File: rtl/spi_slave_mux.sv
// SPI slave: command byte selects a channel read or an addressed config write.
module spi_slave_mux
  import spi_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CPOL   = 0,
  parameter int unsigned CFG_AW = 3
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     sclk_in,
  input  logic                     ss_n_in,
  input  logic                     mosi_in,
  output logic                     miso_out,
  input  logic [NUM_CH*DATA_W-1:0] chan_data_in,
  input  logic [NUM_CH-1:0]        chan_load_in,
  output logic [7:0]               cfg_data_out,
  output logic [CFG_AW-1:0]        cfg_addr_out,
  output logic                     cfg_valid_out,
  output logic [NUM_CH-1:0]        new_flags_out,
  output logic                     irq_out,
  output logic                     frame_err_out
);

  spi_state_t        r_state, w_state_n;
  logic [CNT_W-1:0]  r_bit_cnt, w_cnt_n;
  logic [CMD_W-1:0]  r_cmd, w_cmd_n, w_cmd_cur;
  logic [7:0]        r_wr_data, w_wr_n, w_wr_cur;
  logic [DATA_W-1:0] r_tx_sr, w_tx_n, w_snap;
  logic              r_skip, w_skip_n;
  logic              r_cfg_valid, w_cfg_valid_n;
  logic [CFG_AW-1:0] r_cfg_addr, w_cfg_addr_n;
  logic [7:0]        r_cfg_data, w_cfg_data_n;
  logic              r_frame_err, w_err_n;
  logic [NUM_CH-1:0] r_flags, w_flags_n, w_clr, w_hit;
  logic              r_irq;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_bit_idx;

  logic w_sample, w_shift, w_ss_start, w_ss_end, w_mosi;

  spi_edge_sync #(.CPOL(CPOL)) u_sync (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_sclk        (sclk_in),
    .i_ss_n        (ss_n_in),
    .i_mosi        (mosi_in),
    .o_sample_edge (w_sample),
    .o_shift_edge  (w_shift),
    .o_ss_start    (w_ss_start),
    .o_ss_end      (w_ss_end),
    .o_mosi        (w_mosi)
  );

  // Bytes are filled by bit index (MSB first) so the completed byte is visible
  // combinationally in the cycle of its 8th sample edge.
  assign w_bit_idx = 3'(CMD_W - 1) - r_bit_cnt[2:0];

  always_comb begin
    w_cmd_cur            = r_cmd;
    w_cmd_cur[w_bit_idx] = w_mosi;
    w_wr_cur             = r_wr_data;
    w_wr_cur[w_bit_idx]  = w_mosi;
  end

  assign w_addr = w_cmd_cur[ADDR_MSB:ADDR_LSB];

  always_comb begin
    w_snap = '0;
    w_hit  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (w_addr == ADDR_W'(k)) begin
        w_snap   = chan_data_in[k*DATA_W +: DATA_W];
        w_hit[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_bit_cnt;
    w_cmd_n       = r_cmd;
    w_wr_n        = r_wr_data;
    w_tx_n        = r_tx_sr;
    w_skip_n      = r_skip;
    w_cfg_valid_n = 1'b0;
    w_cfg_addr_n  = r_cfg_addr;
    w_cfg_data_n  = r_cfg_data;
    w_err_n       = 1'b0;
    w_clr         = '0;

    case (r_state)
      ST_IDLE: begin
        w_tx_n = '0;
        if (w_ss_start) begin
          w_state_n = ST_CMD;
          w_cnt_n   = '0;
          w_cmd_n   = '0;
        end
      end
      ST_CMD: begin
        if (w_ss_end) begin
          w_state_n = ST_IDLE;
          w_err_n   = 1'b1;
          w_cnt_n   = '0;
          w_tx_n    = '0;
        end else if (w_sample) begin
          w_cmd_n = w_cmd_cur;
          w_cnt_n = r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(CMD_W - 1)) begin
            w_cnt_n = '0;
            if (w_cmd_cur[CMD_WR_BIT]) begin
              w_state_n = ST_WR_DATA;
              w_wr_n    = '0;
            end else begin
              w_state_n = ST_RD_DATA;
              w_skip_n  = 1'b1;
              if (|w_hit) begin
                w_tx_n = w_snap;
                w_clr  = w_hit;
              end else begin
                w_tx_n  = '0;
                w_err_n = 1'b1;
              end
            end
          end
        end
      end
      ST_WR_DATA: begin
        if (w_ss_end) begin
          w_state_n = ST_IDLE;
          w_err_n   = 1'b1;
          w_cnt_n   = '0;
        end else if (w_sample) begin
          w_wr_n  = w_wr_cur;
          w_cnt_n = r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(7)) begin
            w_cnt_n       = '0;
            w_cfg_valid_n = 1'b1;
            w_cfg_addr_n  = r_cmd[CFG_AW-1:0];
            w_cfg_data_n  = w_wr_cur;
            w_state_n     = ST_WAIT_SS;
          end
        end
      end
      ST_RD_DATA: begin
        if (w_ss_end) begin
          w_state_n = ST_IDLE;
          w_err_n   = 1'b1;
          w_cnt_n   = '0;
          w_tx_n    = '0;
        end else if (w_shift) begin
          // The shift edge right after the load would discard the MSB before it is sampled.
          if (r_skip) w_skip_n = 1'b0;
          else        w_tx_n   = {r_tx_sr[DATA_W-2:0], 1'b0};
        end else if (w_sample) begin
          w_cnt_n = r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_cnt_n   = '0;
            w_state_n = ST_WAIT_SS;
          end
        end
      end
      ST_WAIT_SS: begin
        if (w_ss_end) begin
          w_state_n = ST_IDLE;
          w_cnt_n   = '0;
          w_tx_n    = '0;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
        w_tx_n    = '0;
      end
    endcase
  end

  // A load in the snapshot cycle wins so the new value is still reported as unread.
  assign w_flags_n = (r_flags & ~w_clr) | chan_load_in;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_cmd       <= '0;
      r_wr_data   <= '0;
      r_tx_sr     <= '0;
      r_skip      <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_frame_err <= 1'b0;
      r_flags     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_cnt_n;
      r_cmd       <= w_cmd_n;
      r_wr_data   <= w_wr_n;
      r_tx_sr     <= w_tx_n;
      r_skip      <= w_skip_n;
      r_cfg_valid <= w_cfg_valid_n;
      r_cfg_addr  <= w_cfg_addr_n;
      r_cfg_data  <= w_cfg_data_n;
      r_frame_err <= w_err_n;
      r_flags     <= w_flags_n;
      r_irq       <= |r_flags;
    end
  end

  assign miso_out      = r_tx_sr[DATA_W-1];
  assign cfg_valid_out = r_cfg_valid;
  assign cfg_addr_out  = r_cfg_addr;
  assign cfg_data_out  = r_cfg_data;
  assign frame_err_out = r_frame_err;
  assign new_flags_out = r_flags;
  assign irq_out       = r_irq;

endmodule

// File: tb/tb_spi_slave_mux.sv
// Directed bench: one CPOL=0 and one CPOL=1 slave driven by a bit-banged SPI master.
module tb_spi_slave_mux;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        sclk0 = 1'b0, ss0 = 1'b1, mosi0 = 1'b0;
  logic        sclk1 = 1'b1, ss1 = 1'b1, mosi1 = 1'b0;
  logic [47:0] chan_data = 48'hA5A5_0000_0000;
  logic [2:0]  chan_load = 3'b000;

  logic       miso0, cfg_valid0, irq0, err0;
  logic [7:0] cfg_data0;
  logic [2:0] cfg_addr0, flags0;
  logic       miso1, cfg_valid1, irq1, err1;
  logic [7:0] cfg_data1;
  logic [2:0] cfg_addr1, flags1;

  int total = 0;
  int bad = 0;
  int cfg_cnt0 = 0;
  int err_cnt0 = 0;
  int err_cnt1 = 0;
  logic [2:0] cfg_addr_seen = '0;
  logic [7:0] cfg_data_seen = '0;

  always #5 clk = ~clk;

  spi_slave_mux #(.NUM_CH(3), .DATA_W(16), .CPOL(0), .CFG_AW(3)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .sclk_in(sclk0), .ss_n_in(ss0), .mosi_in(mosi0),
    .miso_out(miso0), .chan_data_in(chan_data), .chan_load_in(chan_load),
    .cfg_data_out(cfg_data0), .cfg_addr_out(cfg_addr0), .cfg_valid_out(cfg_valid0),
    .new_flags_out(flags0), .irq_out(irq0), .frame_err_out(err0)
  );

  spi_slave_mux #(.NUM_CH(3), .DATA_W(16), .CPOL(1), .CFG_AW(3)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .sclk_in(sclk1), .ss_n_in(ss1), .mosi_in(mosi1),
    .miso_out(miso1), .chan_data_in(chan_data), .chan_load_in(chan_load),
    .cfg_data_out(cfg_data1), .cfg_addr_out(cfg_addr1), .cfg_valid_out(cfg_valid1),
    .new_flags_out(flags1), .irq_out(irq1), .frame_err_out(err1)
  );

  always @(negedge clk) begin
    if (cfg_valid0) begin
      cfg_cnt0++;
      cfg_addr_seen = cfg_addr0;
      cfg_data_seen = cfg_data0;
    end
    if (err0) err_cnt0++;
    if (err1) err_cnt1++;
  end

  // SPI master, SCLK = clk/8; collide pulses chan_load[0] in ch0's snapshot cycle.
  task automatic spi_frame(input bit m, input int nbits, input logic [31:0] tx,
                           input bit collide, input bit end_frame, output logic [31:0] rx);
    rx = '0;
    if (m) ss1 = 1'b0; else ss0 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (m) mosi1 = tx[i]; else mosi0 = tx[i];
      repeat (4) @(negedge clk);
      rx = {rx[30:0], (m ? miso1 : miso0)};
      if (m) sclk1 = 1'b0; else sclk0 = 1'b1;
      if (collide && i == nbits - 8) begin
        repeat (2) @(negedge clk);
        chan_load[0] = 1'b1;
        @(negedge clk);
        chan_load[0] = 1'b0;
        chan_data[15:0] = 16'h1234;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      if (m) sclk1 = 1'b1; else sclk0 = 1'b0;
    end
    if (end_frame) begin
      repeat (4) @(negedge clk);
      if (m) ss1 = 1'b1; else ss0 = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({miso0, cfg_valid0, cfg_data0, cfg_addr0, flags0, irq0, err0} !== 17'h0) begin
      bad++;
      $display("FAIL reset_dut0 got=%h exp=0", {miso0, cfg_valid0, cfg_data0, cfg_addr0, flags0, irq0, err0});
    end
    total++;
    if ({miso1, cfg_valid1, cfg_data1, cfg_addr1, flags1, irq1, err1} !== 17'h0) begin
      bad++;
      $display("FAIL reset_dut1 got=%h exp=0", {miso1, cfg_valid1, cfg_data1, cfg_addr1, flags1, irq1, err1});
    end
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cfg_write();
    logic [31:0] rx;
    int c0, e0;
    c0 = cfg_cnt0; e0 = err_cnt0;
    spi_frame(1'b0, 16, 32'h0000_835A, 1'b0, 1'b1, rx);
    total++;
    if (cfg_cnt0 - c0 !== 1) begin bad++; $display("FAIL cfgwr_pulses got=%0d exp=1", cfg_cnt0 - c0); end
    total++;
    if (cfg_addr_seen !== 3'd3) begin bad++; $display("FAIL cfgwr_addr got=%0d exp=3", cfg_addr_seen); end
    total++;
    if (cfg_data_seen !== 8'h5A) begin bad++; $display("FAIL cfgwr_data got=%h exp=5a", cfg_data_seen); end
    total++;
    if (err_cnt0 - e0 !== 0) begin bad++; $display("FAIL cfgwr_err got=%0d exp=0", err_cnt0 - e0); end
  endtask

  task automatic test_chan_read();
    logic [31:0] rx;
    int e0;
    chan_data[31:16] = 16'hBEEF;
    chan_load = 3'b010;
    @(negedge clk);
    chan_load = 3'b000;
    repeat (3) @(negedge clk);
    total++;
    if (flags0 !== 3'b010 || irq0 !== 1'b1) begin
      bad++; $display("FAIL read_flag_set got=%b/%b exp=010/1", flags0, irq0);
    end
    e0 = err_cnt0;
    spi_frame(1'b0, 24, 32'h0001_0000, 1'b0, 1'b1, rx);
    total++;
    if (rx[15:0] !== 16'hBEEF) begin bad++; $display("FAIL read_data got=%h exp=beef", rx[15:0]); end
    total++;
    if (flags0 !== 3'b000 || irq0 !== 1'b0) begin
      bad++; $display("FAIL read_flag_clr got=%b/%b exp=000/0", flags0, irq0);
    end
    total++;
    if (err_cnt0 - e0 !== 0) begin bad++; $display("FAIL read_err got=%0d exp=0", err_cnt0 - e0); end
  endtask

  task automatic test_invalid_addr();
    logic [31:0] rx;
    int e0;
    chan_load = 3'b100;
    @(negedge clk);
    chan_load = 3'b000;
    repeat (3) @(negedge clk);
    e0 = err_cnt0;
    spi_frame(1'b0, 24, 32'h0005_0000, 1'b0, 1'b1, rx);
    total++;
    if (rx[15:0] !== 16'h0000) begin bad++; $display("FAIL badaddr_data got=%h exp=0000", rx[15:0]); end
    total++;
    if (err_cnt0 - e0 !== 1) begin bad++; $display("FAIL badaddr_err got=%0d exp=1", err_cnt0 - e0); end
    total++;
    if (flags0 !== 3'b100) begin bad++; $display("FAIL badaddr_flags got=%b exp=100", flags0); end
  endtask

  task automatic test_abort();
    logic [31:0] rx;
    int c0, e0;
    c0 = cfg_cnt0; e0 = err_cnt0;
    spi_frame(1'b0, 12, 32'h0000_0835, 1'b0, 1'b1, rx);
    total++;
    if (cfg_cnt0 - c0 !== 0) begin bad++; $display("FAIL abort_cfg got=%0d exp=0", cfg_cnt0 - c0); end
    total++;
    if (err_cnt0 - e0 !== 1) begin bad++; $display("FAIL abort_err got=%0d exp=1", err_cnt0 - e0); end
    c0 = cfg_cnt0; e0 = err_cnt0;
    spi_frame(1'b0, 16, 32'h0000_8211, 1'b0, 1'b1, rx);
    total++;
    if (cfg_cnt0 - c0 !== 1 || cfg_addr_seen !== 3'd2 || cfg_data_seen !== 8'h11) begin
      bad++; $display("FAIL abort_next got=%0d/%0d/%h exp=1/2/11", cfg_cnt0 - c0, cfg_addr_seen, cfg_data_seen);
    end
    total++;
    if (err_cnt0 - e0 !== 0) begin bad++; $display("FAIL abort_next_err got=%0d exp=0", err_cnt0 - e0); end
  endtask

  task automatic test_cpol1_collision();
    logic [31:0] rx;
    int e1;
    chan_data[15:0] = 16'h8001;
    e1 = err_cnt1;
    spi_frame(1'b1, 24, 32'h0000_0000, 1'b0, 1'b1, rx);
    total++;
    if (rx[15:0] !== 16'h8001) begin bad++; $display("FAIL cpol1_data got=%h exp=8001", rx[15:0]); end
    total++;
    if (err_cnt1 - e1 !== 0) begin bad++; $display("FAIL cpol1_err got=%0d exp=0", err_cnt1 - e1); end
    spi_frame(1'b1, 24, 32'h0000_0000, 1'b1, 1'b1, rx);
    total++;
    if (rx[15:0] !== 16'h8001) begin bad++; $display("FAIL collide_data got=%h exp=8001", rx[15:0]); end
    total++;
    if (flags1[0] !== 1'b1) begin bad++; $display("FAIL collide_flag got=%b exp=1", flags1[0]); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    spi_frame(1'b0, 12, 32'h0000_0010, 1'b0, 1'b0, rx);
    n_rst = 1'b0;
    @(negedge clk);
    total++;
    if ({miso0, cfg_valid0, cfg_data0, cfg_addr0, flags0, irq0, err0} !== 17'h0) begin
      bad++;
      $display("FAIL midrst_outputs got=%h exp=0", {miso0, cfg_valid0, cfg_data0, cfg_addr0, flags0, irq0, err0});
    end
    sclk0 = 1'b0;
    ss0 = 1'b1;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    spi_frame(1'b0, 24, 32'h0001_0000, 1'b0, 1'b1, rx);
    total++;
    if (rx[15:0] !== 16'hBEEF) begin bad++; $display("FAIL midrst_next got=%h exp=beef", rx[15:0]); end
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_chan_read();
    test_invalid_addr();
    test_abort();
    test_cpol1_collision();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
